bcd_display_driver: RTL and testbench
=====================================

BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default DATA_WIDTH from arch_defs_pkg (8), width of the computer output value.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clocks per displayed digit; legal minimum 2.
REQ-003 SHALL have port clk, input, 1, the single system clock; all flops on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port out_val, input, DATA_WIDTH, unsigned value from the computer output register (final_out).
REQ-006 SHALL have port load, input, 1, one-cycle strobe: out_val is valid and must be converted.
REQ-007 SHALL have port seg, output, 7, active-low segments ordered {g,f,e,d,c,b,a}.
REQ-008 SHALL have port an, output, 4, active-low digit enables; an[0] is the ones digit.
REQ-009 SHALL have port busy, output, 1, high while a conversion is in progress.

Function
REQ-010 SHALL convert with a sequential double-dabble (add-3-then-shift-left), one input bit per clock, into 3 BCD digits (hundreds, tens, ones).
REQ-011 SHALL implement FSM states IDLE, SHIFT and DONE: IDLE->SHIFT on the edge sampling load=1 (edge E0, value captured, busy=1); SHIFT for edges E1..E8, one bit per edge, ->DONE at E8; DONE->IDLE at E9, committing the result to the display digits and dropping busy.
REQ-012 SHALL keep busy high from the edge after E0 through E9, i.e. exactly 9 cycles, and display the new digits from E9 on.
REQ-013 SHALL leave the displayed digits unchanged until commit, so no partial result is ever shown.
REQ-014 SHALL, on load while busy, capture out_val into a one-deep pending register and set a pending flag; a later load while busy overwrites it (last value wins).
REQ-015 SHALL, at E9 with pending set, commit the current result, clear pending and start the pending value (E9 acts as E0), with busy staying high.
REQ-016 SHALL ignore load in DONE except as a pending capture per REQ-014.
REQ-017 SHALL scan digits 0,1,2,3,0,... advancing every REFRESH_DIV clocks, driving exactly one an bit low.
REQ-018 SHALL drive digit 3 permanently blank (seg=7'h7F while selected).
REQ-019 SHALL blank leading zeros: hundreds is blank when 0; tens is blank when hundreds and tens are both 0; ones is always shown.
REQ-020 SHALL use these decodes: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, blank=0x7F.

Reset
REQ-021 SHALL, while reset is low, immediately force seg=7'h7F, an=4'hF, busy=0, state IDLE, pending cleared, displayed digits 0, and scan index and counter 0.
REQ-022 SHALL, after reset release, display "  0" (digit 0 selected first), with any conversion in flight discarded.

Structure
REQ-023 SHALL take DATA_WIDTH from arch_defs_pkg; the FSM state enum, the SEG_BLANK constant and the digit encodings SHALL be added to arch_defs_pkg.
REQ-024 SHALL place the digit-to-segment decode in one combinational sub-module, seg7_decoder (4-bit BCD plus blank in, 7-bit seg out).

Verification
REQ-025 Reset check: hold reset low mid-scan -> seg=7F, an=F, busy=0 asynchronously; after release an[0]=0 and seg=0x40.
REQ-026 Conversion check: load with out_val=255 -> busy high 9 cycles; after E9 the digits read 2,5,5 (0x24, 0x12, 0x12).
REQ-027 Blanking check: out_val=7 -> digit2 and digit1 = 0x7F, digit0 = 0x78; out_val=0 -> digit0 = 0x40 and the rest blank.
REQ-028 Back-to-back check: load 100; load 42 at busy cycle 3; load 99 at busy cycle 5 -> "100" is displayed, then "99" after a further 9 cycles; 42 is never committed; busy stays continuously high.
REQ-029 Scan check: REFRESH_DIV=4 -> an cycles 1110,1101,1011,0111,1110 with 4 clocks each; digit3 seg=7F.
REQ-030 Reset-mid-operation check: reset low at busy cycle 4 of a load of 200 -> busy=0 at once; after release "  0" is shown and 200 never appears.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: datapath width, display FSM states and
// seven-segment encodings (active-low, ordered {g,f,e,d,c,b,a}).
package arch_defs_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index n holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decode with blanking.
module seg7_decoder
    import arch_defs_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg_c = SEG_DIGITS[0];
                4'd1:    seg_c = SEG_DIGITS[1];
                4'd2:    seg_c = SEG_DIGITS[2];
                4'd3:    seg_c = SEG_DIGITS[3];
                4'd4:    seg_c = SEG_DIGITS[4];
                4'd5:    seg_c = SEG_DIGITS[5];
                4'd6:    seg_c = SEG_DIGITS[6];
                4'd7:    seg_c = SEG_DIGITS[7];
                4'd8:    seg_c = SEG_DIGITS[8];
                4'd9:    seg_c = SEG_DIGITS[9];
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter feeding a multiplexed
// 4-digit seven-segment display with leading-zero blanking.
module bcd_display_driver #(
    parameter int unsigned DATA_WIDTH  = arch_defs_pkg::DATA_WIDTH,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] out_val,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [3:0]            an,
    output logic                  busy
);

    import arch_defs_pkg::*;

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    disp_state_t           state, state_d;
    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;
    logic [DATA_WIDTH-1:0] pend_val, pend_val_d;
    logic                  pend_flag, pend_flag_d;
    logic [BCD_W-1:0]      disp_q, disp_d;
    logic                  busy_d;
    logic [1:0]            scan_idx, scan_d;
    logic [REF_W-1:0]      ref_cnt, ref_cnt_d;
    logic [3:0]            an_d;
    logic [3:0]            sel_bcd;
    logic                  sel_blank;
    logic [6:0]            seg_c;
    logic [BCD_W+DATA_WIDTH-1:0] shift_c;

    // Add-3 correction on every BCD nibble that is 5 or more.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shift_c = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};

    // Conversion FSM, pending-load capture and display commit.
    always_comb begin
        state_d     = state;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        bit_cnt_d   = bit_cnt;
        pend_val_d  = pend_val;
        pend_flag_d = pend_flag;
        disp_d      = disp_q;
        case (state)
            IDLE: begin
                if (load) begin
                    bin_d     = out_val;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d     = shift_c[BCD_W+DATA_WIDTH-1:DATA_WIDTH];
                bin_d     = shift_c[DATA_WIDTH-1:0];
                bit_cnt_d = bit_cnt + BIT_W'(1);
                if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                    state_d = DONE;
                end
                if (load) begin
                    pend_val_d  = out_val;
                    pend_flag_d = 1'b1;
                end
            end
            DONE: begin
                disp_d = bcd_q;
                // A load sampled here is newer than any pending value, so it wins.
                if (load || pend_flag) begin
                    bin_d       = load ? out_val : pend_val;
                    bcd_d       = '0;
                    bit_cnt_d   = '0;
                    pend_flag_d = 1'b0;
                    state_d     = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Digit scan timing; outputs are registered from next-state values.
    always_comb begin
        ref_cnt_d = ref_cnt + REF_W'(1);
        scan_d    = scan_idx;
        if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            scan_d    = scan_idx + 2'd1;
        end
        an_d = ~(4'b0001 << scan_d);
        case (scan_d)
            2'd0: begin
                sel_bcd   = disp_d[3:0];
                sel_blank = 1'b0;
            end
            2'd1: begin
                sel_bcd   = disp_d[7:4];
                sel_blank = (disp_d[11:4] == 8'd0);
            end
            2'd2: begin
                sel_bcd   = disp_d[11:8];
                sel_blank = (disp_d[11:8] == 4'd0);
            end
            default: begin
                sel_bcd   = 4'd0;
                sel_blank = 1'b1;
            end
        endcase
    end

    seg7_decoder u_dec (
        .bcd   (sel_bcd),
        .blank (sel_blank),
        .seg_c (seg_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            bit_cnt   <= '0;
            pend_val  <= '0;
            pend_flag <= 1'b0;
            disp_q    <= '0;
            busy      <= 1'b0;
            scan_idx  <= 2'd0;
            ref_cnt   <= '0;
            seg       <= SEG_BLANK;
            an        <= 4'hF;
        end else begin
            state     <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_cnt   <= bit_cnt_d;
            pend_val  <= pend_val_d;
            pend_flag <= pend_flag_d;
            disp_q    <= disp_d;
            busy      <= busy_d;
            scan_idx  <= scan_d;
            ref_cnt   <= ref_cnt_d;
            seg       <= seg_c;
            an        <= an_d;
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: loads push the expected committed
// value, a monitor scans the multiplexed display after each commit.
module tb_bcd_display_driver;

    localparam int unsigned DW = 8;
    localparam int unsigned RD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] out_val = '0;
    logic          load = 1'b0;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    bit mon_active = 1'b0;

    bcd_display_driver #(.DATA_WIDTH(DW), .REFRESH_DIV(RD)) dut (
        .clk     (clk),
        .reset   (reset),
        .out_val (out_val),
        .load    (load),
        .seg     (seg),
        .an      (an),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference: what digit position idx must show for decimal value v.
    function automatic logic [6:0] expected_seg(input int v, input int idx);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (idx)
            0: return seg_of(o);
            1: return (h == 0 && t == 0) ? 7'h7F : seg_of(t);
            2: return (h == 0) ? 7'h7F : seg_of(h);
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int an_index(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic read_display(output logic [3:0][6:0] segs, output bit ok);
        bit [3:0] seen = '0;
        segs = '1;
        ok = 1'b0;
        for (int n = 0; n < int'(4 * RD + 8); n++) begin
            int idx;
            @(negedge clk);
            idx = an_index(an);
            if (idx >= 0) begin
                seen[idx] = 1'b1;
                segs[idx] = seg;
            end
            if (seen == 4'hF) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_display(input string tag, input int v);
        logic [3:0][6:0] segs;
        bit ok;
        read_display(segs, ok);
        check($sformatf("%s_scan_complete", tag), 32'(ok), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_v%0d_digit%0d", tag, v, i), 32'(segs[i]), 32'(expected_seg(v, i)));
        end
    endtask

    // Monitor: each normal busy fall is a commit; verify the full display.
    initial begin
        logic busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && busy_prev && !busy) begin
                mon_active = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit actual=commit expected=none");
                end else begin
                    int v;
                    v = exp_q.pop_front();
                    check_display("commit", v);
                end
                mon_active = 1'b0;
            end
            busy_prev = busy;
        end
    end

    task automatic load_value(input int v);
        @(negedge clk);
        out_val = DW'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic count_busy(input string name, input int expected);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'(expected));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || mon_active || busy) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("wait_idle_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_an;
        int s;

        // Reset state and post-reset display.
        #1 reset = 1'b0;
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_an", 32'(an), 32'hE);
        check("post_rst_seg", 32'(seg), 32'h40);

        // Scan order and dwell time.
        prev_an = an;
        for (int n = 0; n < 10 && an == prev_an; n++) @(negedge clk);
        s = an_index(an);
        check("scan_align", 32'(s >= 0), 32'd1);
        for (int k = 0; k <= int'(4 * RD); k++) begin
            int idx;
            logic [3:0] exp_an;
            idx = (s + k / int'(RD)) % 4;
            exp_an = ~(4'b0001 << idx);
            check($sformatf("scan_an_k%0d", k), 32'(an), 32'(exp_an));
            if (idx == 3) check($sformatf("scan_d3_k%0d", k), 32'(seg), 32'h7F);
            @(negedge clk);
        end

        // Full-scale conversion with busy length.
        exp_q.push_back(255);
        load_value(255);
        count_busy("busy_len_255", 9);
        wait_idle();

        // Asynchronous reset mid-scan.
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel_rst_an", 32'(an), 32'hE);
        check("rel_rst_seg", 32'(seg), 32'h40);

        // Leading-zero blanking.
        exp_q.push_back(7);
        load_value(7);
        wait_idle();
        exp_q.push_back(0);
        load_value(0);
        wait_idle();

        // Back-to-back: 100 then pending 42 overwritten by 99.
        exp_q.push_back(99);
        load_value(100);
        for (int c = 1; c <= 19; c++) begin
            if (c == 3) begin out_val = DW'(42); load = 1'b1; end
            if (c == 5) begin out_val = DW'(99); load = 1'b1; end
            if (c == 4 || c == 6) load = 1'b0;
            check($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'(c <= 18));
            if (c >= 10 && c <= 18 && an_index(an) >= 0) begin
                check($sformatf("b2b_show100_c%0d", c), 32'(seg),
                      32'(expected_seg(100, an_index(an))));
            end
            if (c < 19) @(negedge clk);
        end
        wait_idle();

        // Reset in the middle of a conversion of 200.
        load_value(200);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midop_rst_busy", 32'(busy), 32'd0);
        check("midop_rst_seg", 32'(seg), 32'h7F);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_display("midop_after", 0);
        repeat (12) @(negedge clk);
        check("midop_no_busy", 32'(busy), 32'd0);
        check_display("midop_later", 0);

        // Randomized conversions.
        for (int i = 0; i < 20; i++) begin
            int v;
            v = int'($urandom_range(0, 255));
            exp_q.push_back(v);
            load_value(v);
            count_busy($sformatf("busy_len_rand%0d", i), 9);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
